// File: rtl/dcache_resp_if.sv
// -----------------------------------------------------------------------------
// dcache_resp_if
//
// Purpose:
//   Bundles the data-cache request/response handshake and the backing-memory
//   bus used by dcache_resp into one interface.
//
// Modports:
//   slave  - the dcache_resp responder. Takes requests and memory returns,
//            drives responses and memory requests.
//   master - the requester side (ID stage plus backing memory). Used by the
//            surrounding system or by a testbench.
//
// Signals (direction as seen from the slave):
//   dcache_req_valid_i   in   request present
//   dcache_wen_i         in   1 = store, 0 = load
//   dcache_addr_i        in   byte address
//   dcache_wdata_i       in   store data, right-aligned
//   dcache_wlen_i        in   size: 0=1B, 1=2B, 2=4B, 3=8B
//   dcache_req_ready_o   out  request accepted when valid & ready
//   dcache_resp_valid_o  out  response available
//   dcache_resp_ready_i  in   consumer takes response
//   dcache_rdata_o       out  load data, right-aligned, zero-extended
//   dcache_resp_err_o    out  error, qualified by resp_valid
//   dcache_busy_o        out  transaction outstanding
//   mem_req_o            out  memory request
//   mem_we_o             out  memory write
//   mem_addr_o           out  doubleword-aligned address
//   mem_wdata_o          out  store data on its byte lane
//   mem_strb_o           out  byte enables
//   mem_gnt_i            in   memory accepted request
//   mem_rvalid_i         in   read data valid
//   mem_rdata_i          in   read data, full doubleword
// -----------------------------------------------------------------------------
interface dcache_resp_if;

    // Request side
    logic        dcache_req_valid_i;
    logic        dcache_wen_i;
    logic [63:0] dcache_addr_i;
    logic [63:0] dcache_wdata_i;
    logic [1:0]  dcache_wlen_i;
    logic        dcache_req_ready_o;

    // Response side
    logic        dcache_resp_valid_o;
    logic        dcache_resp_ready_i;
    logic [63:0] dcache_rdata_o;
    logic        dcache_resp_err_o;
    logic        dcache_busy_o;

    // Backing memory
    logic        mem_req_o;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_strb_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [63:0] mem_rdata_i;

    modport slave (
        input  dcache_req_valid_i,
        input  dcache_wen_i,
        input  dcache_addr_i,
        input  dcache_wdata_i,
        input  dcache_wlen_i,
        output dcache_req_ready_o,
        output dcache_resp_valid_o,
        input  dcache_resp_ready_i,
        output dcache_rdata_o,
        output dcache_resp_err_o,
        output dcache_busy_o,
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        output mem_strb_o,
        input  mem_gnt_i,
        input  mem_rvalid_i,
        input  mem_rdata_i
    );

    modport master (
        output dcache_req_valid_i,
        output dcache_wen_i,
        output dcache_addr_i,
        output dcache_wdata_i,
        output dcache_wlen_i,
        input  dcache_req_ready_o,
        input  dcache_resp_valid_o,
        output dcache_resp_ready_i,
        input  dcache_rdata_o,
        input  dcache_resp_err_o,
        input  dcache_busy_o,
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        input  mem_strb_o,
        output mem_gnt_i,
        output mem_rvalid_i,
        output mem_rdata_i
    );

endinterface

// File: rtl/dcache_resp.sv
// -----------------------------------------------------------------------------
// dcache_resp
//
// Purpose:
//   Responder end of the ID-stage data-cache request interface. It accepts one
//   load/store at a time and turns it into an aligned 64-bit backing-memory
//   transaction with byte strobes. It returns right-aligned, unextended load
//   data (or a write acknowledge) over a valid/ready response handshake.
//   dcache_busy_o stalls the pipeline while a transaction is outstanding.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - dcache_resp_if.slave (request, response and memory signals)
//
// Optional feature:
//   DCACHE_RESP_TIMEOUT_EN - when defined, an 8-bit counter aborts a
//   transaction that sits in REQ or WAIT for TIMEOUT_CYCLES cycles. The
//   transaction then completes with err=1 and rdata=0. When undefined, REQ and
//   WAIT wait indefinitely and err reports misalignment only.
//
// Timing (gnt in the first REQ cycle, rvalid one cycle after gnt), counted from
// the accept cycle T:
//   store      -> resp_valid at T+2
//   load       -> resp_valid at T+3
//   misaligned -> resp_valid at T+1, with no memory access
// -----------------------------------------------------------------------------
module dcache_resp
`ifdef DCACHE_RESP_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255  // 1..255
)
`endif
(
    input  logic          clk,
    input  logic          rst,
    dcache_resp_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // The address must be a multiple of the access size (2^wlen bytes).
    function automatic logic is_misaligned(input logic [2:0] off,
                                           input logic [1:0] wlen);
        logic mis;
        unique case (wlen)
            2'd0:    mis = 1'b0;
            2'd1:    mis = off[0];
            2'd2:    mis = |off[1:0];
            default: mis = |off;
        endcase
        return mis;
    endfunction

    // Build the byte-enable mask ((1 << 2^wlen) - 1) << off, truncated to 8 bits.
    function automatic logic [7:0] calc_strb(input logic [2:0] off,
                                             input logic [1:0] wlen);
        logic [15:0] span;
        span = (16'd1 << (5'd1 << wlen)) - 16'd1;
        span = span << off;
        return span[7:0];
    endfunction

    // Move right-aligned store data onto its byte lane.
    function automatic logic [63:0] lane_wdata(input logic [63:0] wdata,
                                               input logic [2:0]  off);
        return wdata << {off, 3'b000};
    endfunction

    // Right-align the addressed bytes of a full doubleword and zero the rest.
    // No sign extension here; the consumer does that.
    function automatic logic [63:0] extract_load(input logic [63:0] raw,
                                                 input logic [2:0]  off,
                                                 input logic [1:0]  wlen);
        logic [63:0] sh;
        logic [63:0] res;
        sh = raw >> {off, 3'b000};
        unique case (wlen)
            2'd0:    res = {56'd0, sh[7:0]};
            2'd1:    res = {48'd0, sh[15:0]};
            2'd2:    res = {32'd0, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e      state_q, state_d;

    // Captured request
    logic        wen_q,   wen_d;
    logic [63:0] addr_q,  addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [1:0]  wlen_q,  wlen_d;

    // Registered outputs
    logic        req_ready_q,  req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [63:0] rdata_q,      rdata_d;
    logic        err_q,        err_d;
    logic        busy_q,       busy_d;
    logic        mem_req_q,    mem_req_d;
    logic        mem_we_q,     mem_we_d;
    logic [63:0] mem_addr_q,   mem_addr_d;
    logic [63:0] mem_wdata_q,  mem_wdata_d;
    logic [7:0]  mem_strb_q,   mem_strb_d;

`ifdef DCACHE_RESP_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
`endif

    // req_ready_q is high exactly in IDLE, so this is valid & ready.
    logic accept;
    assign accept = req_ready_q & bus.dcache_req_valid_i;

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wlen_d  = wlen_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wen_d   = bus.dcache_wen_i;
                    addr_d  = bus.dcache_addr_i;
                    wdata_d = bus.dcache_wdata_i;
                    wlen_d  = bus.dcache_wlen_i;
                    rdata_d = '0;
                    if (is_misaligned(bus.dcache_addr_i[2:0], bus.dcache_wlen_i)) begin
                        // Report the error directly; memory is never touched.
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_REQ;
                    end
                end
            end

            S_REQ: begin
                if (bus.mem_gnt_i) begin
                    // Writes are posted: the grant alone completes them.
                    state_d = wen_q ? S_RESP : S_WAIT;
                end
`ifdef DCACHE_RESP_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end
`endif
            end

            S_WAIT: begin
                if (bus.mem_rvalid_i) begin
                    rdata_d = extract_load(bus.mem_rdata_i, addr_q[2:0], wlen_q);
                    state_d = S_RESP;
                end
`ifdef DCACHE_RESP_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end
`endif
            end

            S_RESP: begin
                // rdata/err hold until the consumer takes them.
                if (bus.dcache_resp_ready_i) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Outputs are functions of the next state and are registered. This
        // keeps them glitch-free and clears them at once on reset.
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        busy_d       = (state_d != S_IDLE);
        mem_req_d    = (state_d == S_REQ);
        mem_we_d     = mem_req_d & wen_d;
        mem_addr_d   = mem_req_d ? {addr_d[63:3], 3'b000} : '0;
        mem_strb_d   = mem_req_d ? calc_strb(addr_d[2:0], wlen_d) : '0;
        mem_wdata_d  = (mem_req_d && wen_d) ? lane_wdata(wdata_d, addr_d[2:0]) : '0;

`ifdef DCACHE_RESP_TIMEOUT_EN
        // Clear on entry to REQ or WAIT, and count each cycle spent there.
        if ((state_d == S_REQ || state_d == S_WAIT) && state_d == state_q)
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        else
            tmo_cnt_d = '0;
`endif
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments everywhere in sequential logic, so
            // every flop samples pre-edge values regardless of statement order.
            state_q      <= S_IDLE;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wlen_q       <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_strb_q   <= '0;
`ifdef DCACHE_RESP_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wlen_q       <= wlen_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_strb_q   <= mem_strb_d;
`ifdef DCACHE_RESP_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Output drive
    // -------------------------------------------------------------------------
    assign bus.dcache_req_ready_o  = req_ready_q;
    assign bus.dcache_resp_valid_o = resp_valid_q;
    assign bus.dcache_rdata_o      = rdata_q;
    assign bus.dcache_resp_err_o   = err_q;
    assign bus.dcache_busy_o       = busy_q;
    assign bus.mem_req_o           = mem_req_q;
    assign bus.mem_we_o            = mem_we_q;
    assign bus.mem_addr_o          = mem_addr_q;
    assign bus.mem_wdata_o         = mem_wdata_q;
    assign bus.mem_strb_o          = mem_strb_q;

endmodule
